fp16_frame_argmin: RTL and testbench

- Streaming reduction stage directly downstream of the FP16 comparison datapath in the annealing core.
- Consumes one frame of FP16 energy samples over a valid/ready stream and tracks the minimum energy and its position in the frame.
- After the last sample it emits a single result beat: best energy, its index, the sample count and status flags.
- Each incoming sample is ordered against the current best by an internal fp_comparator instance (num1 > num2 → result=1).

---
 rtl/fp16_frame_argmin.sv | 239 +++++++++++++++++++++++
 tb/tb_fp16_frame_argmin.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_frame_argmin.sv
// fp16_frame_argmin
//   Streaming arg-min reduction over one frame of FP16 energy samples.
//   Samples arrive on a valid/ready stream; after the in_last beat a single
//   result beat carries the smallest energy, its 0-based position in the
//   frame, the saturating sample count and status flags.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready input handshake; in_data/in_last sampled on accept
//   in_data           FP16 energy sample
//   in_last           marks the final sample of the frame
//   out_valid/out_ready result handshake; result held stable until taken
//   out_min           minimum energy (16'h7E00 when no non-NaN sample)
//   out_idx           index of out_min within the frame
//   out_count         accepted sample count, saturating at 2^IDX_W-1
//   out_nan_seen      at least one NaN sample was accepted
//   out_empty         no non-NaN sample was accepted
//   out_overflow      a sample was accepted while the count was saturated

// fp_comparator
//   Combinational IEEE-754 binary16 ordering: result=1 when num1 > num2.
//   +0 and -0 compare equal; a NaN on either side yields result=0.
module fp_comparator #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] num1,
  input  logic [DATA_WIDTH-1:0] num2,
  output logic                  result
);

  logic                  sign1_s;
  logic                  sign2_s;
  logic [DATA_WIDTH-2:0] mag1_s;
  logic [DATA_WIDTH-2:0] mag2_s;
  logic                  nan1_s;
  logic                  nan2_s;

  assign sign1_s = num1[DATA_WIDTH-1];
  assign sign2_s = num2[DATA_WIDTH-1];
  assign mag1_s  = num1[DATA_WIDTH-2:0];
  assign mag2_s  = num2[DATA_WIDTH-2:0];
  assign nan1_s  = (num1[14:10] == 5'h1F) && (num1[9:0] != 10'h000);
  assign nan2_s  = (num2[14:10] == 5'h1F) && (num2[9:0] != 10'h000);

  // Sign-magnitude ordering; negative values order by reversed magnitude.
  always_comb begin
    result = 1'b0;
    if (nan1_s || nan2_s) begin
      result = 1'b0;
    end else if ((mag1_s == 15'h0000) && (mag2_s == 15'h0000)) begin
      result = 1'b0;
    end else if (sign1_s != sign2_s) begin
      result = ~sign1_s;
    end else if (sign1_s == 1'b0) begin
      result = (mag1_s > mag2_s);
    end else begin
      result = (mag1_s < mag2_s);
    end
  end

endmodule

module fp16_frame_argmin #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_W      = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_min,
  output logic [IDX_W-1:0]      out_idx,
  output logic [IDX_W-1:0]      out_count,
  output logic                  out_nan_seen,
  output logic                  out_empty,
  output logic                  out_overflow
);

  localparam logic [DATA_WIDTH-1:0] QNAN      = 16'h7E00;
  localparam logic [DATA_WIDTH-1:0] NEG_ZERO  = 16'h8000;
  localparam logic [DATA_WIDTH-1:0] POS_ZERO  = 16'h0000;
  localparam logic [IDX_W-1:0]      CNT_ZERO  = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]      CNT_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]      CNT_MAX   = {IDX_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic                  in_ready_r;
  logic                  out_valid_r;

  logic [DATA_WIDTH-1:0] best_r;
  logic [IDX_W-1:0]      idx_r;
  logic [IDX_W-1:0]      count_r;
  logic                  nan_seen_r;
  logic                  have_best_r;
  logic                  overflow_r;

  logic [DATA_WIDTH-1:0] best_nxt_s;
  logic [IDX_W-1:0]      idx_nxt_s;
  logic [IDX_W-1:0]      count_nxt_s;
  logic                  nan_seen_nxt_s;
  logic                  have_best_nxt_s;
  logic                  overflow_nxt_s;

  logic                  accept_s;
  logic                  handshake_s;
  logic [DATA_WIDTH-1:0] sample_s;
  logic                  sample_nan_s;
  logic                  best_gt_s;

  assign accept_s     = in_valid && in_ready_r;
  assign handshake_s  = out_valid_r && out_ready;

  // -0 folds onto +0 so the stored minimum is always canonical.
  assign sample_s     = (in_data == NEG_ZERO) ? POS_ZERO : in_data;
  assign sample_nan_s = (sample_s[14:10] == 5'h1F) && (sample_s[9:0] != 10'h000);

  // best_r only reaches the comparator as a real value once have_best_r is
  // set; before that the result is ignored by the update rule.
  fp_comparator #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_cmp (
    .num1  (best_r),
    .num2  (sample_s),
    .result(best_gt_s)
  );

  // Frame state transitions.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_nxt_s = in_last ? S_DONE : S_ACCUM;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ACCUM: begin
        if (accept_s && in_last) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_ACCUM;
        end
      end
      S_DONE: begin
        if (handshake_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Next values for the frame accumulators; cleared on the result handshake.
  always_comb begin
    best_nxt_s      = best_r;
    idx_nxt_s       = idx_r;
    count_nxt_s     = count_r;
    nan_seen_nxt_s  = nan_seen_r;
    have_best_nxt_s = have_best_r;
    overflow_nxt_s  = overflow_r;
    if (handshake_s) begin
      best_nxt_s      = QNAN;
      idx_nxt_s       = CNT_ZERO;
      count_nxt_s     = CNT_ZERO;
      nan_seen_nxt_s  = 1'b0;
      have_best_nxt_s = 1'b0;
      overflow_nxt_s  = 1'b0;
    end else if (accept_s) begin
      if (count_r == CNT_MAX) begin
        overflow_nxt_s = 1'b1;
      end else begin
        count_nxt_s = count_r + CNT_ONE;
      end
      if (sample_nan_s) begin
        nan_seen_nxt_s = 1'b1;
      end else if (!have_best_r || best_gt_s) begin
        // Strict compare: an equal sample never displaces the earlier index.
        best_nxt_s      = sample_s;
        idx_nxt_s       = count_r;
        have_best_nxt_s = 1'b1;
      end else begin
        best_nxt_s = best_r;
      end
    end else begin
      best_nxt_s = best_r;
    end
  end

  // State, handshake flags and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      best_r      <= QNAN;
      idx_r       <= CNT_ZERO;
      count_r     <= CNT_ZERO;
      nan_seen_r  <= 1'b0;
      have_best_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s != S_DONE);
      out_valid_r <= (state_nxt_s == S_DONE);
      best_r      <= best_nxt_s;
      idx_r       <= idx_nxt_s;
      count_r     <= count_nxt_s;
      nan_seen_r  <= nan_seen_nxt_s;
      have_best_r <= have_best_nxt_s;
      overflow_r  <= overflow_nxt_s;
    end
  end

  assign in_ready     = in_ready_r;
  assign out_valid    = out_valid_r;
  assign out_min      = best_r;
  assign out_idx      = idx_r;
  assign out_count    = count_r;
  assign out_nan_seen = nan_seen_r;
  assign out_empty    = ~have_best_r;
  assign out_overflow = overflow_r;

endmodule

// File: tb/tb_fp16_frame_argmin.sv
// Directed testbench for fp16_frame_argmin: a table of whole frames with
// hand-computed results, plus sequences for back-pressure, overflow on a
// narrow-count instance, and mid-frame reset.
module tb_fp16_frame_argmin;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_min;
  logic [9:0]  out_idx;
  logic [9:0]  out_count;
  logic        out_nan_seen;
  logic        out_empty;
  logic        out_overflow;

  logic        b_in_valid;
  logic        b_in_ready;
  logic [15:0] b_in_data;
  logic        b_in_last;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [15:0] b_out_min;
  logic [2:0]  b_out_idx;
  logic [2:0]  b_out_count;
  logic        b_out_nan_seen;
  logic        b_out_empty;
  logic        b_out_overflow;

  int checks;
  int failures;

  fp16_frame_argmin dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_min(out_min),
    .out_idx(out_idx), .out_count(out_count), .out_nan_seen(out_nan_seen),
    .out_empty(out_empty), .out_overflow(out_overflow)
  );

  fp16_frame_argmin #(.DATA_WIDTH(16), .IDX_W(3)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_min(b_out_min),
    .out_idx(b_out_idx), .out_count(b_out_count), .out_nan_seen(b_out_nan_seen),
    .out_empty(b_out_empty), .out_overflow(b_out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic [15:0] d0, d1, d2, d3;
    logic [15:0] emin;
    logic [9:0]  eidx;
    logic [9:0]  ecnt;
    logic        enan;
    logic        eempty;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(int n, logic [15:0] a, logic [15:0] b, logic [15:0] c,
                              logic [15:0] d, logic [15:0] emin, logic [9:0] eidx,
                              logic [9:0] ecnt, logic enan, logic eempty);
    vec_t v;
    v.n = n; v.d0 = a; v.d1 = b; v.d2 = c; v.d3 = d;
    v.emin = emin; v.eidx = eidx; v.ecnt = ecnt; v.enan = enan; v.eempty = eempty;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Present one sample at the negedge; it is accepted at the next posedge.
  task automatic send(input logic [15:0] d, input logic last, input string tag);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
  endtask

  // Result check at the cycle after the last beat, then handshake and clear check.
  task automatic check_result(input string tag, input logic [15:0] emin, input logic [9:0] eidx,
                              input logic [9:0] ecnt, input logic enan, input logic eempty,
                              input logic eovf);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_in_ready_done"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_min"}, {16'd0, out_min}, {16'd0, emin});
    chk({tag, "_idx"}, {22'd0, out_idx}, {22'd0, eidx});
    chk({tag, "_count"}, {22'd0, out_count}, {22'd0, ecnt});
    chk({tag, "_nan"}, {31'd0, out_nan_seen}, {31'd0, enan});
    chk({tag, "_empty"}, {31'd0, out_empty}, {31'd0, eempty});
    chk({tag, "_ovf"}, {31'd0, out_overflow}, {31'd0, eovf});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_cleared_count"}, {22'd0, out_count}, 32'd0);
    chk({tag, "_cleared_min"}, {16'd0, out_min}, 32'h7E00);
    chk({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [15:0] s;
    for (int i = 0; i < v.n; i++) begin
      case (i)
        0: s = v.d0;
        1: s = v.d1;
        2: s = v.d2;
        default: s = v.d3;
      endcase
      send(s, (i == v.n - 1), tag);
    end
    check_result(tag, v.emin, v.eidx, v.ecnt, v.enan, v.eempty, 1'b0);
  endtask

  initial begin
    logic [15:0] held_min;
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = 16'h0000; in_last = 1'b0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = 16'h0000; b_in_last = 1'b0; b_out_ready = 1'b0;

    vecs[0] = mk(4, 16'h3C00, 16'h4000, 16'hBC00, 16'hC000, 16'hC000, 10'd3, 10'd4, 1'b0, 1'b0);
    vecs[1] = mk(3, 16'h4000, 16'h3C00, 16'h3C00, 16'h0000, 16'h3C00, 10'd1, 10'd3, 1'b0, 1'b0);
    vecs[2] = mk(4, 16'h70ED, 16'h515D, 16'hAC4A, 16'hBC43, 16'hBC43, 10'd3, 10'd4, 1'b0, 1'b0);
    vecs[3] = mk(4, 16'h8000, 16'h7E00, 16'h7C00, 16'h0000, 16'h0000, 10'd0, 10'd4, 1'b1, 1'b0);
    vecs[4] = mk(1, 16'h7E00, 16'h0000, 16'h0000, 16'h0000, 16'h7E00, 10'd0, 10'd1, 1'b1, 1'b1);
    vecs[5] = mk(2, 16'hFC00, 16'h7C00, 16'h0000, 16'h0000, 16'hFC00, 10'd0, 10'd2, 1'b0, 1'b0);
    vecs[6] = mk(1, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 10'd0, 10'd1, 1'b0, 1'b0);

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_min", {16'd0, out_min}, 32'h7E00);
    chk("rst_idx", {22'd0, out_idx}, 32'd0);
    chk("rst_count", {22'd0, out_count}, 32'd0);
    chk("rst_flags", {28'd0, out_nan_seen, out_empty, out_overflow, 1'b0}, 32'd4);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    for (int k = 0; k < 7; k++) begin
      run_vec(vecs[k], $sformatf("vec%0d", k));
    end

    // Back-pressure: result held while next frame waits upstream
    send(16'h3C00, 1'b0, "bp");
    send(16'hC400, 1'b1, "bp");
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h4400; in_last = 1'b1;
    held_min = 16'hC400;
    for (int c = 0; c < 5; c++) begin
      chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      chk("bp_valid_held", {31'd0, out_valid}, 32'd1);
      chk("bp_min_held", {16'd0, out_min}, {16'd0, held_min});
      chk("bp_idx_held", {22'd0, out_idx}, 32'd1);
      chk("bp_count_held", {22'd0, out_count}, 32'd2);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_after_hs_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_after_hs_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    check_result("bp_next", 16'h4400, 10'd0, 10'd1, 1'b0, 1'b0, 1'b0);

    // Overflow on the IDX_W=3 instance: 9 samples
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      b_in_valid = 1'b1; b_in_data = 16'h3C00; b_in_last = (i == 8);
      chk("ovf_in_ready", {31'd0, b_in_ready}, 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    b_in_valid = 1'b0; b_in_last = 1'b0;
    chk("ovf_valid", {31'd0, b_out_valid}, 32'd1);
    chk("ovf_count", {29'd0, b_out_count}, 32'd7);
    chk("ovf_flag", {31'd0, b_out_overflow}, 32'd1);
    chk("ovf_idx", {29'd0, b_out_idx}, 32'd0);
    chk("ovf_min", {16'd0, b_out_min}, 32'h3C00);
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    chk("ovf_cleared", {31'd0, b_out_overflow}, 32'd0);

    // Reset mid-frame
    send(16'h3C00, 1'b0, "mrst");
    send(16'h3800, 1'b0, "mrst");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mrst_count", {22'd0, out_count}, 32'd0);
    chk("mrst_min", {16'd0, out_min}, 32'h7E00);
    @(negedge clk);
    chk("mrst_in_ready_hold", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_in_ready_rel", {31'd0, in_ready}, 32'd1);
    chk("mrst_no_result", {31'd0, out_valid}, 32'd0);
    send(16'h4000, 1'b1, "mrst_next");
    check_result("mrst_next", 16'h4000, 10'd0, 10'd1, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
